// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory-port arbiter: FSM states, requester ids
// and default memory geometry.
package cpu_mem_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 32;
    localparam int NUM_REQ    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_e;

    // Requester ids double as bit positions in the request vector.
    typedef enum logic [1:0] {
        REQ_IR = 2'd0,
        REQ_LD = 2'd1,
        REQ_ST = 2'd2
    } req_id_e;

    function automatic logic [1:0] next_id(input logic [1:0] id);
        return (id == 2'd2) ? 2'd0 : id + 2'd1;
    endfunction

endpackage

// File: rtl/arb_select.sv
// Combinational winner pick among fetch/load/store requests.
// ARB_RR_EN defined: round-robin from i_rr_ptr; undefined: STORE > LOAD > FETCH with fetch override.
module arb_select
    import cpu_mem_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_starve,
    input  logic [1:0]         i_rr_ptr,
    output logic               o_valid,
    output logic [1:0]         o_winner
);

`ifdef ARB_RR_EN
    logic [1:0] w_cand1;
    logic [1:0] w_cand2;
    logic       w_unused_starve;

    assign w_cand1         = next_id(i_rr_ptr);
    assign w_cand2         = next_id(w_cand1);
    assign w_unused_starve = i_starve;

    always_comb begin
        o_winner = i_rr_ptr;
        if (i_req[i_rr_ptr])
            o_winner = i_rr_ptr;
        else if (i_req[w_cand1])
            o_winner = w_cand1;
        else if (i_req[w_cand2])
            o_winner = w_cand2;
    end
`else
    logic [1:0] w_unused_ptr;

    assign w_unused_ptr = i_rr_ptr;

    // A starved fetch overrides the fixed order; otherwise older pipeline stages drain first.
    always_comb begin
        o_winner = REQ_IR;
        if (i_starve && i_req[REQ_IR])
            o_winner = REQ_IR;
        else if (i_req[REQ_ST])
            o_winner = REQ_ST;
        else if (i_req[REQ_LD])
            o_winner = REQ_LD;
    end
`endif

    assign o_valid = |i_req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between CPU fetch, load and store streams, one access at a time.
// Build option ARB_RR_EN: round-robin arbitration instead of fixed priority with fetch starvation guard.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 4
)(
    input  logic              clk,
    input  logic              resetn,
    input  logic              ir_req,
    input  logic [ADDR_W-1:0] ir_adrs,
    output logic              ir_gnt,
    output logic              ir_rvalid,
    output logic [DATA_W-1:0] ir_rdata,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_adrs,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_adrs,
    input  logic [DATA_W-1:0] st_wdata,
    output logic              st_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adrs,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_stall,
    output arb_state_e        dbg_state
);

    localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

    arb_state_e          r_state;
    logic [1:0]          r_win_id;
    logic [2:0]          r_lat_cnt;
    logic                r_ir_gnt;
    logic                r_ld_gnt;
    logic                r_st_gnt;
    logic                r_ir_rvalid;
    logic                r_ld_rvalid;
    logic [DATA_W-1:0]   r_ir_rdata;
    logic [DATA_W-1:0]   r_ld_rdata;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_adrs;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic [NUM_REQ-1:0]  w_req;
    logic                w_valid;
    logic [1:0]          w_win;
    logic                w_starve;
    logic [1:0]          w_rr_ptr;
    logic [ADDR_W-1:0]   w_win_adrs;
    logic                w_multi;

    assign w_req = {st_req, ld_req, ir_req};

`ifdef ARB_RR_EN
    logic [1:0] r_rr_ptr;

    assign w_starve = 1'b0;
    assign w_rr_ptr = r_rr_ptr;

    // Pointer moves to one past each winner so every requester gets a turn.
    always_ff @(posedge clk) begin
        if (!resetn)
            r_rr_ptr <= REQ_IR;
        else if (r_state == IDLE && w_valid)
            r_rr_ptr <= next_id(w_win);
    end
`else
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    logic [3:0] r_starve_cnt;

    assign w_starve = (r_starve_cnt == STARVE_MAX);
    assign w_rr_ptr = REQ_IR;

    always_ff @(posedge clk) begin
        if (!resetn)
            r_starve_cnt <= 4'd0;
        else if (!ir_req)
            r_starve_cnt <= 4'd0;
        else if (r_state == IDLE && w_valid) begin
            if (w_win == REQ_IR)
                r_starve_cnt <= 4'd0;
            else if (r_starve_cnt != STARVE_MAX)
                r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end
`endif

    arb_select u_arb_select (
        .i_req    (w_req),
        .i_starve (w_starve),
        .i_rr_ptr (w_rr_ptr),
        .o_valid  (w_valid),
        .o_winner (w_win)
    );

    always_comb begin
        w_win_adrs = ir_adrs;
        case (w_win)
            REQ_LD:  w_win_adrs = ld_adrs;
            REQ_ST:  w_win_adrs = st_adrs;
            default: w_win_adrs = ir_adrs;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_win_id    <= REQ_IR;
            r_lat_cnt   <= 3'd0;
            r_ir_gnt    <= 1'b0;
            r_ld_gnt    <= 1'b0;
            r_st_gnt    <= 1'b0;
            r_ir_rvalid <= 1'b0;
            r_ld_rvalid <= 1'b0;
            r_ir_rdata  <= '0;
            r_ld_rdata  <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_adrs  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_ir_gnt    <= 1'b0;
            r_ld_gnt    <= 1'b0;
            r_st_gnt    <= 1'b0;
            r_ir_rvalid <= 1'b0;
            r_ld_rvalid <= 1'b0;
            r_mem_en    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_state    <= CMD;
                        r_win_id   <= w_win;
                        r_mem_en   <= 1'b1;
                        r_mem_we   <= (w_win == REQ_ST);
                        r_mem_adrs <= w_win_adrs;
                        if (w_win == REQ_ST)
                            r_mem_wdata <= st_wdata;
                        r_ir_gnt   <= (w_win == REQ_IR);
                        r_ld_gnt   <= (w_win == REQ_LD);
                        r_st_gnt   <= (w_win == REQ_ST);
                    end
                end
                CMD: begin
                    r_lat_cnt <= LAT_INIT;
                    r_state   <= r_mem_we ? IDLE : WAIT;
                end
                WAIT: begin
                    // Read data is captured straight into the winner's output register.
                    if (r_lat_cnt == 3'd0) begin
                        r_state <= RESP;
                        if (r_win_id == REQ_IR) begin
                            r_ir_rdata  <= mem_rdata;
                            r_ir_rvalid <= 1'b1;
                        end else begin
                            r_ld_rdata  <= mem_rdata;
                            r_ld_rvalid <= 1'b1;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 3'd1;
                    end
                end
                RESP: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_multi   = (ir_req & ld_req) | (ir_req & st_req) | (ld_req & st_req);
    assign cpu_stall = (r_state != IDLE) | w_multi;

    assign ir_gnt    = r_ir_gnt;
    assign ld_gnt    = r_ld_gnt;
    assign st_gnt    = r_st_gnt;
    assign ir_rvalid = r_ir_rvalid;
    assign ld_rvalid = r_ld_rvalid;
    assign ir_rdata  = r_ir_rdata;
    assign ld_rdata  = r_ld_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_adrs  = r_mem_adrs;
    assign mem_wdata = r_mem_wdata;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with RD_LAT=1, one with RD_LAT=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_port_arbiter;
    import cpu_mem_pkg::*;

    localparam int AW = 11;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance with RD_LAT=1
    logic          resetn;
    logic          ir_req, ld_req, st_req;
    logic [AW-1:0] ir_adrs, ld_adrs, st_adrs;
    logic [DW-1:0] st_wdata;
    logic          ir_gnt, ld_gnt, st_gnt, ir_rvalid, ld_rvalid;
    logic [DW-1:0] ir_rdata, ld_rdata;
    logic          mem_en, mem_we, cpu_stall;
    logic [AW-1:0] mem_adrs;
    logic [DW-1:0] mem_wdata, mem_rdata;
    arb_state_e    dbg_state;

    // instance with RD_LAT=3
    logic          b_resetn;
    logic          b_ir_req, b_ld_req, b_st_req;
    logic [AW-1:0] b_ir_adrs, b_ld_adrs, b_st_adrs;
    logic [DW-1:0] b_st_wdata;
    logic          b_ir_gnt, b_ld_gnt, b_st_gnt, b_ir_rvalid, b_ld_rvalid;
    logic [DW-1:0] b_ir_rdata, b_ld_rdata;
    logic          b_mem_en, b_mem_we, b_cpu_stall;
    logic [AW-1:0] b_mem_adrs;
    logic [DW-1:0] b_mem_wdata, b_mem_rdata;
    arb_state_e    b_dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .STARVE_LIMIT(4)) u_dut (
        .clk(clk), .resetn(resetn),
        .ir_req(ir_req), .ir_adrs(ir_adrs), .ir_gnt(ir_gnt), .ir_rvalid(ir_rvalid), .ir_rdata(ir_rdata),
        .ld_req(ld_req), .ld_adrs(ld_adrs), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .st_req(st_req), .st_adrs(st_adrs), .st_wdata(st_wdata), .st_gnt(st_gnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_adrs(mem_adrs), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .cpu_stall(cpu_stall), .dbg_state(dbg_state)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .STARVE_LIMIT(4)) u_dut3 (
        .clk(clk), .resetn(b_resetn),
        .ir_req(b_ir_req), .ir_adrs(b_ir_adrs), .ir_gnt(b_ir_gnt), .ir_rvalid(b_ir_rvalid), .ir_rdata(b_ir_rdata),
        .ld_req(b_ld_req), .ld_adrs(b_ld_adrs), .ld_gnt(b_ld_gnt), .ld_rvalid(b_ld_rvalid), .ld_rdata(b_ld_rdata),
        .st_req(b_st_req), .st_adrs(b_st_adrs), .st_wdata(b_st_wdata), .st_gnt(b_st_gnt),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_adrs(b_mem_adrs), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .cpu_stall(b_cpu_stall), .dbg_state(b_dbg_state)
    );

    // Power-up memory contents; a few known words, the rest a recognisable pattern.
    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        case (a)
            11'h010: return 32'hA5A5_0001;
            11'h001: return 32'h1111_0001;
            11'h020: return 32'h2222_0002;
            11'h005: return 32'h5555_0005;
            default: return {21'h0, a} ^ 32'hC0DE_0000;
        endcase
    endfunction

    bit [DW-1:0] mem_a [0:2047];
    bit          wr_a  [0:2047];
    always @(posedge clk) begin
        mem_rdata <= wr_a[mem_adrs] ? mem_a[mem_adrs] : init_word(mem_adrs);
        if (mem_en && mem_we) begin
            mem_a[mem_adrs] <= mem_wdata;
            wr_a[mem_adrs]  <= 1'b1;
        end
    end

    logic [DW-1:0] b_pipe1, b_pipe2;
    always @(posedge clk) begin
        b_pipe1     <= init_word(b_mem_adrs);
        b_pipe2     <= b_pipe1;
        b_mem_rdata <= b_pipe2;
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_gnt(output logic [1:0] id);
        id = 2'd3;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (st_gnt)      id = REQ_ST;
            else if (ld_gnt) id = REQ_LD;
            else if (ir_gnt) id = REQ_IR;
            if (id != 2'd3) break;
        end
        check_vec("gnt_seen", 32'(id != 2'd3), 32'd1);
    endtask

    task automatic wait_rvalid(input logic is_ir, output logic [DW-1:0] data);
        logic seen;
        seen = 1'b0;
        data = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (is_ir ? ir_rvalid : ld_rvalid) begin
                seen = 1'b1;
                data = is_ir ? ir_rdata : ld_rdata;
                break;
            end
        end
        check_vec("rvalid_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]    id;
        logic [DW-1:0] data;
        int            n_ld;
        int            lat;
        int            n_rv;
        logic          ir_won;

        resetn = 1'b0; b_resetn = 1'b0;
        ir_req = 1'b1; ld_req = 1'b1; st_req = 1'b1;
        ir_adrs = 11'h010; ld_adrs = 11'h001; st_adrs = 11'h7FF; st_wdata = 32'h1234_5678;
        b_ir_req = 1'b0; b_ld_req = 1'b0; b_st_req = 1'b0;
        b_ir_adrs = '0; b_ld_adrs = '0; b_st_adrs = '0; b_st_wdata = '0;

        // reset held two cycles with every request high
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_vec("rst_ir_gnt", 32'(ir_gnt), 32'd0);
        check_vec("rst_ld_gnt", 32'(ld_gnt), 32'd0);
        check_vec("rst_st_gnt", 32'(st_gnt), 32'd0);
        check_vec("rst_rvalid", 32'({ir_rvalid, ld_rvalid}), 32'd0);
        check_vec("rst_mem_en", 32'(mem_en), 32'd0);
        check_vec("rst_ir_rdata", ir_rdata, 32'd0);
        check_vec("rst_ld_rdata", ld_rdata, 32'd0);
        check_vec("rst_state", 32'(dbg_state), 32'(IDLE));
        check_vec("rst_stall_multi", 32'(cpu_stall), 32'd1);
        check_vec("rst3_mem_en", 32'(b_mem_en), 32'd0);
        ir_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
        resetn = 1'b1; b_resetn = 1'b1;
        @(negedge clk);
        check_vec("idle_stall", 32'(cpu_stall), 32'd0);

        // single fetch, RD_LAT=1
        ir_req = 1'b1; ir_adrs = 11'h010;
        @(negedge clk);
        check_vec("t2_ir_gnt", 32'(ir_gnt), 32'd1);
        check_vec("t2_mem_en", 32'(mem_en), 32'd1);
        check_vec("t2_mem_we", 32'(mem_we), 32'd0);
        check_vec("t2_mem_adrs", 32'(mem_adrs), 32'h010);
        ir_req = 1'b0;
        @(negedge clk);
        check_vec("t2_early_rvalid", 32'(ir_rvalid), 32'd0);
        check_vec("t2_gnt_pulse", 32'(ir_gnt), 32'd0);
        @(negedge clk);
        check_vec("t2_ir_rvalid", 32'(ir_rvalid), 32'd1);
        check_vec("t2_ir_rdata", ir_rdata, 32'hA5A5_0001);
        @(negedge clk);
        check_vec("t2_rvalid_pulse", 32'(ir_rvalid), 32'd0);
        check_vec("t2_rdata_hold", ir_rdata, 32'hA5A5_0001);
        check_vec("t2_state_idle", 32'(dbg_state), 32'(IDLE));

        // all three request together
        st_req = 1'b1; st_adrs = 11'h7FF; st_wdata = 32'hDEAD_BEEF;
        ld_req = 1'b1; ld_adrs = 11'h001;
        ir_req = 1'b1; ir_adrs = 11'h020;
        #1;
        check_vec("t3_stall_3req", 32'(cpu_stall), 32'd1);
`ifdef ARB_RR_EN
        exp_q.push_back(32'(REQ_LD)); exp_q.push_back(32'(REQ_ST)); exp_q.push_back(32'(REQ_IR));
`else
        exp_q.push_back(32'(REQ_ST)); exp_q.push_back(32'(REQ_LD)); exp_q.push_back(32'(REQ_IR));
`endif
        for (int k = 0; k < 3; k++) begin
            wait_gnt(id);
            check_vec("t3_order", 32'(id), exp_q.pop_front());
            check_vec("t3_stall_cmd", 32'(cpu_stall), 32'd1);
            if (id == REQ_ST) begin
                check_vec("t3_st_we", 32'(mem_we), 32'd1);
                check_vec("t3_st_adrs", 32'(mem_adrs), 32'h7FF);
                check_vec("t3_st_wdata", mem_wdata, 32'hDEAD_BEEF);
                st_req = 1'b0;
            end else if (id == REQ_LD) begin
                check_vec("t3_ld_we", 32'(mem_we), 32'd0);
                ld_req = 1'b0;
                wait_rvalid(1'b0, data);
                check_vec("t3_ld_rdata", data, 32'h1111_0001);
            end else if (id == REQ_IR) begin
                ir_req = 1'b0;
                wait_rvalid(1'b1, data);
                check_vec("t3_ir_rdata", data, 32'h2222_0002);
            end else begin
                st_req = 1'b0; ld_req = 1'b0; ir_req = 1'b0;
            end
        end
        @(negedge clk);
        check_vec("t3_stall_done", 32'(cpu_stall), 32'd0);

        // the stored word reads back
        ld_req = 1'b1; ld_adrs = 11'h7FF;
        wait_gnt(id);
        check_vec("rb_gnt_id", 32'(id), 32'(REQ_LD));
        ld_req = 1'b0;
        wait_rvalid(1'b0, data);
        check_vec("rb_ld_rdata", data, 32'hDEAD_BEEF);
        check_vec("rb_ir_rdata_hold", ir_rdata, 32'h2222_0002);

`ifdef ARB_RR_EN
        // round-robin with every request held: IR, LD, ST repeating from reset
        @(negedge clk);
        resetn = 1'b0;
        ir_req = 1'b1; ld_req = 1'b1; st_req = 1'b1;
        ir_adrs = 11'h020; ld_adrs = 11'h001; st_adrs = 11'h100; st_wdata = 32'h0BAD_F00D;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 9; k++) begin
            wait_gnt(id);
            check_vec("t6_rr_order", 32'(id), 32'(k % 3));
        end
        ir_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
        repeat (6) @(negedge clk);
        check_vec("t6_idle", 32'(dbg_state), 32'(IDLE));
`else
        // fetch starvation: load held continuously
        @(negedge clk);
        ld_req = 1'b1; ld_adrs = 11'h001;
        ir_req = 1'b1; ir_adrs = 11'h033;
        n_ld = 0;
        ir_won = 1'b0;
        for (int g = 0; g < 10; g++) begin
            wait_gnt(id);
            if (id == REQ_IR) begin
                ir_won = 1'b1;
                break;
            end
            if (id == REQ_LD) n_ld++;
            else break;
        end
        check_vec("t4_ir_won", 32'(ir_won), 32'd1);
        check_vec("t4_ld_grants", 32'(n_ld), 32'd4);
        ir_req = 1'b0;
        wait_rvalid(1'b1, data);
        check_vec("t4_ir_rdata", data, 32'hC0DE_0033);
        ir_req = 1'b1;
        wait_gnt(id);
        check_vec("t4_after_clear", 32'(id), 32'(REQ_LD));
        ld_req = 1'b0;
        wait_gnt(id);
        check_vec("t4_ir_alone", 32'(id), 32'(REQ_IR));
        ir_req = 1'b0;
        wait_rvalid(1'b1, data);
        check_vec("t4_ir_rdata2", data, 32'hC0DE_0033);
`endif

        // RD_LAT=3: latency, then reset during WAIT drops the read
        @(negedge clk);
        b_ld_req = 1'b1; b_ld_adrs = 11'h005;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (b_ld_gnt) b_ld_req = 1'b0;
            if (b_ld_rvalid) begin
                lat = i;
                break;
            end
        end
        check_vec("t5_latency", 32'(lat), 32'd5);
        check_vec("t5_rdata", b_ld_rdata, 32'h5555_0005);
        @(negedge clk);
        b_ld_req = 1'b1; b_ld_adrs = 11'h006;
        @(negedge clk);
        check_vec("t5_gnt", 32'(b_ld_gnt), 32'd1);
        b_ld_req = 1'b0;
        @(negedge clk);
        check_vec("t5_in_wait", 32'(b_dbg_state), 32'(WAIT));
        b_resetn = 1'b0;
        @(negedge clk);
        check_vec("t5_state_idle", 32'(b_dbg_state), 32'(IDLE));
        check_vec("t5_no_rvalid", 32'(b_ld_rvalid), 32'd0);
        b_resetn = 1'b1;
        n_rv = 0;
        repeat (8) begin
            @(negedge clk);
            if (b_ld_rvalid) n_rv++;
        end
        check_vec("t5_dropped", 32'(n_rv), 32'd0);
        check_vec("t5_rdata_cleared", b_ld_rdata, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
